rng_cell_picker: RTL and testbench

- Consumer end of the random-number generator. Turns the free-running 12-bit random value into a free grid cell for the VGA game/demo logic.
- On request, samples the random value and rejects values that are out of range or that hit an occupied cell, using a one-cycle occupancy query.
- Returns registered (x, y) cell coordinates with a done/fail handshake.

---
 rtl/rng_pkg.sv | 27 ++
 rtl/rng_cell_picker_cell_index_decode.sv | 17 +
 rtl/rng_cell_picker.sv | 151 +++++++++++++++
 tb/tb_rng_cell_picker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the random-number consumer blocks.
package rng_pkg;

  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 40;
  localparam int CELLS      = GRID_W_DEF * GRID_H_DEF;
  localparam int RND_W      = 12;
  localparam int IDX_W      = 11;
  localparam int COORD_W    = 6;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    QUERY,
    CHECK,
    EXHAUST,
    DONE,
    FAILED
  } picker_state_e;

  // Next linear-scan index; anything at or past the last cell wraps to 0.
  function automatic logic [RND_W-1:0] next_scan_idx(input logic [RND_W-1:0] idx,
                                                     input logic [RND_W-1:0] cells);
    return (idx >= cells - RND_W'(1)) ? '0 : idx + RND_W'(1);
  endfunction

endpackage

// File: rtl/rng_cell_picker_cell_index_decode.sv
// Linear cell index to (column, row) split by constant-divisor divide/modulo.
module cell_index_decode
  import rng_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF
) (
  input  logic [IDX_W-1:0]   idx_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o
);

  localparam logic [IDX_W-1:0] W = IDX_W'(GRID_W);

  assign x_o = COORD_W'(idx_i % W);
  assign y_o = COORD_W'(idx_i / W);

endmodule

// File: rtl/rng_cell_picker.sv
// Picks a free grid cell from the free-running random value, with an occupancy query.
// Build option LINEAR_SCAN_EN: after MAX_TRIES misses, fall back to a wrapping linear scan.
//
// state   | meaning
// IDLE    | waiting for req_i
// SAMPLE  | register rnd_i, reject out-of-range values
// QUERY   | occ_valid_o strobe for the current index
// CHECK   | evaluate occ_hit_i
// EXHAUST | random tries used up; start scan or give up
// DONE    | done_o pulse, new cell on cell_x_o/cell_y_o
// FAILED  | fail_o pulse
module rng_cell_picker
  import rng_pkg::*;
#(
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int MAX_TRIES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RND_W-1:0]   rnd_i,
  input  logic               req_i,
  output logic               busy_o,
  output logic               occ_valid_o,
  output logic [IDX_W-1:0]   occ_addr_o,
  input  logic               occ_hit_i,
  output logic               done_o,
  output logic               fail_o,
  output logic [COORD_W-1:0] cell_x_o,
  output logic [COORD_W-1:0] cell_y_o
);

  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int SCAN_W = $clog2(GRID_W * GRID_H + 1);
  localparam logic [RND_W-1:0]  CELLS_L = RND_W'(GRID_W * GRID_H);
  localparam logic [SCAN_W-1:0] CELLS_S = SCAN_W'(GRID_W * GRID_H);
  localparam logic [TRY_W-1:0]  MAX_T   = TRY_W'(MAX_TRIES);

  picker_state_e state_q, state_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [RND_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   occ_addr_q, occ_addr_d;
  logic [COORD_W-1:0] cell_x_q, cell_x_d;
  logic [COORD_W-1:0] cell_y_q, cell_y_d;
  logic               scan_q, scan_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [COORD_W-1:0] dec_x, dec_y;

  cell_index_decode #(
    .GRID_W(GRID_W)
  ) u_decode (
    .idx_i(idx_q[IDX_W-1:0]),
    .x_o  (dec_x),
    .y_o  (dec_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tries_q    <= '0;
      idx_q      <= '0;
      occ_addr_q <= '0;
      cell_x_q   <= '0;
      cell_y_q   <= '0;
      scan_q     <= 1'b0;
      scan_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      idx_q      <= idx_d;
      occ_addr_q <= occ_addr_d;
      cell_x_q   <= cell_x_d;
      cell_y_q   <= cell_y_d;
      scan_q     <= scan_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    idx_d      = idx_q;
    occ_addr_d = occ_addr_q;
    cell_x_d   = cell_x_q;
    cell_y_d   = cell_y_q;
    scan_d     = scan_q;
    scan_cnt_d = scan_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          tries_d = '0;
          scan_d  = 1'b0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        idx_d = rnd_i;
        if (rnd_i >= CELLS_L) begin
          tries_d = tries_q + TRY_W'(1);
          state_d = (tries_d == MAX_T) ? EXHAUST : SAMPLE;
        end else begin
          occ_addr_d = rnd_i[IDX_W-1:0];
          state_d    = QUERY;
        end
      end
      QUERY: state_d = CHECK;
      CHECK: begin
        if (!occ_hit_i) begin
          cell_x_d = dec_x;
          cell_y_d = dec_y;
          state_d  = DONE;
        end else if (scan_q) begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
          if (scan_cnt_d == CELLS_S) begin
            state_d = FAILED;
          end else begin
            idx_d      = next_scan_idx(idx_q, CELLS_L);
            occ_addr_d = idx_d[IDX_W-1:0];
            state_d    = QUERY;
          end
        end else begin
          tries_d = tries_q + TRY_W'(1);
          state_d = (tries_d == MAX_T) ? EXHAUST : SAMPLE;
        end
      end
      EXHAUST: begin
`ifdef LINEAR_SCAN_EN
        scan_d     = 1'b1;
        scan_cnt_d = '0;
        idx_d      = next_scan_idx(idx_q, CELLS_L);
        occ_addr_d = idx_d[IDX_W-1:0];
        state_d    = QUERY;
`else
        state_d = FAILED;
`endif
      end
      DONE:    state_d = IDLE;
      FAILED:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign occ_valid_o = (state_q == QUERY);
  assign occ_addr_o  = occ_addr_q;
  assign done_o      = (state_q == DONE);
  assign fail_o      = (state_q == FAILED);
  assign cell_x_o    = cell_x_q;
  assign cell_y_o    = cell_y_q;

endmodule

// File: tb/tb_rng_cell_picker.sv
// Directed bench for rng_cell_picker; expected results queued per request and checked on done/fail.
module tb_rng_cell_picker;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] rnd_i;
  logic        req_i;
  logic        busy_o;
  logic        occ_valid_o;
  logic [10:0] occ_addr_o;
  logic        occ_hit_i;
  logic        done_o;
  logic        fail_o;
  logic [5:0]  cell_x_o;
  logic [5:0]  cell_y_o;

  rng_cell_picker dut (
    .clk        (clk),
    .reset      (reset),
    .rnd_i      (rnd_i),
    .req_i      (req_i),
    .busy_o     (busy_o),
    .occ_valid_o(occ_valid_o),
    .occ_addr_o (occ_addr_o),
    .occ_hit_i  (occ_hit_i),
    .done_o     (done_o),
    .fail_o     (fail_o),
    .cell_x_o   (cell_x_o),
    .cell_y_o   (cell_y_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_fail;
    int cyc;
    int x;
    int y;
    int nq;
    int first_addr;
    int first_qcyc;
  } exp_t;

  exp_t sb[$];
  int   rnd_q[$];
  bit   occ_mem[0:2047];
  int   hits_left     = 0;
  int   req_pulse_cyc = -1;
  int   n_checks      = 0;
  int   n_err         = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_occ(input bit v);
    for (int i = 0; i < 2048; i++) occ_mem[i] = v;
  endtask

  task automatic push_exp(input bit f, input int cyc, input int x, input int y,
                          input int nq, input int fa, input int fc);
    exp_t e;
    e.is_fail = f; e.cyc = cyc; e.x = x; e.y = y;
    e.nq = nq; e.first_addr = fa; e.first_qcyc = fc;
    sb.push_back(e);
  endtask

  task automatic start_req(input int r);
    @(negedge clk);
    rnd_i = 12'(r);
    req_i = 1'b1;
    @(posedge clk);
  endtask

  // Cycle c is the interval after edge c-1; edge 0 is the one that accepted req_i.
  task automatic wait_result(input string tag, input int budget);
    int   nq = 0;
    int   fq_addr = -1;
    int   fq_cyc = -1;
    bit   got = 1'b0;
    exp_t e;
    for (int c = 1; c <= budget && !got; c++) begin
      @(negedge clk);
      req_i = (c == req_pulse_cyc);
      if (occ_valid_o) begin
        if (nq == 0) begin
          fq_addr = int'(occ_addr_o);
          fq_cyc  = c;
        end
        nq++;
        if (hits_left > 0) begin
          occ_hit_i = 1'b1;
          hits_left--;
        end else begin
          occ_hit_i = occ_mem[occ_addr_o];
        end
      end
      if (done_o || fail_o) begin
        got = 1'b1;
        chk({tag, ".sb_nonempty"}, sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, ".done"}, done_o, !e.is_fail);
          chk({tag, ".fail"}, fail_o, e.is_fail);
          chk({tag, ".cycle"}, c, e.cyc);
          chk({tag, ".x"}, cell_x_o, e.x);
          chk({tag, ".y"}, cell_y_o, e.y);
          chk({tag, ".queries"}, nq, e.nq);
          chk({tag, ".first_addr"}, fq_addr, e.first_addr);
          chk({tag, ".first_qcyc"}, fq_cyc, e.first_qcyc);
        end
      end
      if (rnd_q.size() > 0) rnd_i = 12'(rnd_q.pop_front());
    end
    chk({tag, ".finished_in_budget"}, got, 1);
    @(negedge clk);
    req_i = 1'b0;
    req_pulse_cyc = -1;
    chk({tag, ".busy_after"}, busy_o, 0);
    chk({tag, ".pulse_width"}, done_o | fail_o, 0);
  endtask

  task automatic idle_watch(input string tag, input int n);
    int act = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy_o || occ_valid_o || done_o || fail_o) act++;
    end
    chk(tag, act, 0);
  endtask

  initial begin
    reset = 1'b1;
    req_i = 1'b0;
    rnd_i = '0;
    occ_hit_i = 1'b0;
    set_occ(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", busy_o, 0);
    chk("rst.occ_valid", occ_valid_o, 0);
    chk("rst.occ_addr", occ_addr_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.fail", fail_o, 0);
    chk("rst.x", cell_x_o, 0);
    chk("rst.y", cell_y_o, 0);
    reset = 1'b0;

    // Empty grid, single draw of 291.
    push_exp(1'b0, 4, 11, 7, 1, 291, 2);
    start_req(291);
    wait_result("t1", 40);

    // Two out-of-range draws, then the last cell.
    rnd_q = '{1700, 1700, 1599};
    push_exp(1'b0, 6, 39, 39, 1, 1599, 4);
    start_req(1700);
    wait_result("t2", 40);

    // Two occupied answers, then free; a req_i pulse while busy must be dropped.
    hits_left = 2;
    req_pulse_cyc = 3;
    push_exp(1'b0, 10, 5, 0, 3, 5, 2);
    start_req(5);
    wait_result("t3", 40);
    idle_watch("t3.no_requeue", 8);

    // Every cell occupied.
    set_occ(1'b1);
`ifdef LINEAR_SCAN_EN
    push_exp(1'b1, 3250, 5, 0, 1616, 100, 2);
`else
    push_exp(1'b1, 50, 5, 0, 16, 100, 2);
`endif
    start_req(100);
    wait_result("t4", 3400);

`ifdef LINEAR_SCAN_EN
    // Random draws stuck on 1599; scan wraps to 0, 1, 2.
    set_occ(1'b1);
    occ_mem[2] = 1'b0;
    push_exp(1'b0, 56, 2, 0, 19, 1599, 2);
    start_req(1599);
    wait_result("t5", 200);
`endif

    // Reset during CHECK with a stray request while busy.
    set_occ(1'b0);
    start_req(10);
    @(negedge clk);
    req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    chk("t6.query", occ_valid_o, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6.busy", busy_o, 0);
    chk("t6.occ_valid", occ_valid_o, 0);
    chk("t6.occ_addr", occ_addr_o, 0);
    chk("t6.done", done_o, 0);
    chk("t6.fail", fail_o, 0);
    chk("t6.x", cell_x_o, 0);
    chk("t6.y", cell_y_o, 0);
    reset = 1'b0;
    idle_watch("t6.quiet", 10);
    chk("t6.sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
